// File: rtl/mm_arbiter.sv
// -----------------------------------------------------------------------------
// mm_arbiter
//
// Shares one combinational Montgomery multiplier (normal_mm, kept outside this
// block) between two requesters. Operands are accepted round-robin into an
// operand register (S1). The multiplier sits between S1 and the result
// register (S2), and S2 drives a tagged valid/ready response channel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_* / req1_*             operand channels (valid/ready, a, b, tag)
//   mm_in1, mm_in2              operands to the shared multiplier (from S1 only)
//   mm_out                      multiplier result, combinational in mm_in1/mm_in2
//   rsp_valid/ready/id/tag/data result channel; rsp_id names the requester
//
// Parameters
//   DW  operand/result width
//   TW  tag width (tags pass through untouched)
// -----------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 14
`endif

module mm_arbiter #(
    parameter int DW = `DATAWIDTH,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [TW-1:0] req0_tag,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [TW-1:0] req1_tag,

    output logic [DW-1:0] mm_in1,
    output logic [DW-1:0] mm_in2,
    input  logic [DW-1:0] mm_out,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [TW-1:0] rsp_tag,
    output logic [DW-1:0] rsp_data
);

    localparam int NREQ = 2;

    // -------------------------------------------------------------------------
    // Requester ports gathered into arrays so selection is a plain index
    // -------------------------------------------------------------------------
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [DW-1:0]   req_a   [NREQ];
    logic [DW-1:0]   req_b   [NREQ];
    logic [TW-1:0]   req_tag [NREQ];

    assign req_valid  = {req1_valid, req0_valid};
    assign req_a[0]   = req0_a;
    assign req_a[1]   = req1_a;
    assign req_b[0]   = req0_b;
    assign req_b[1]   = req1_b;
    assign req_tag[0] = req0_tag;
    assign req_tag[1] = req1_tag;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic          last_reg;       // requester granted on the most recent accept
    logic          s1_v_reg;
    logic          s1_id_reg;
    logic [TW-1:0] s1_tag_reg;
    logic [DW-1:0] s1_a_reg;
    logic [DW-1:0] s1_b_reg;

    logic          s2_v_reg;
    logic          s2_id_reg;
    logic [TW-1:0] s2_tag_reg;
    logic [DW-1:0] s2_data_reg;

    // -------------------------------------------------------------------------
    // Pipeline flow control
    // -------------------------------------------------------------------------
    logic s2_free;
    logic s1_adv;
    logic acc_en;

    // S2 can take a new result when empty or being drained this cycle.
    assign s2_free = !s2_v_reg || rsp_ready;
    // S1 moves into S2 whenever it holds something and S2 can take it.
    assign s1_adv  = s1_v_reg && s2_free;
    // S1 can accept when empty or emptying this cycle. Gating with rst_n keeps
    // both ready outputs low for the whole reset pulse.
    assign acc_en  = (!s1_v_reg || s1_adv) && rst_n;

    // -------------------------------------------------------------------------
    // Round-robin arbitration: a tie goes to the requester not granted last.
    // -------------------------------------------------------------------------
    logic grant_valid;
    logic grant_id;

    always_comb begin
        grant_valid = |req_valid;
        grant_id    = 1'b0;
        if (&req_valid) begin
            grant_id = !last_reg;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = acc_en && grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    // A grant implies the granted requester is valid, so an accept is simply
    // a grant while S1 can take it.
    logic          accept;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [TW-1:0] sel_tag;

    assign accept  = grant_valid && acc_en;
    assign sel_a   = req_a[grant_id];
    assign sel_b   = req_b[grant_id];
    assign sel_tag = req_tag[grant_id];

    // -------------------------------------------------------------------------
    // Arbitration history
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;   // requester 0 wins the first tie
        end else if (accept) begin
            last_reg <= grant_id;
        end
    end

    // -------------------------------------------------------------------------
    // S1: operand register. Loads on accept; empties when it advances with no
    // new accept behind it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg   <= 1'b0;
            s1_id_reg  <= 1'b0;
            s1_tag_reg <= '0;
            s1_a_reg   <= '0;
            s1_b_reg   <= '0;
        end else if (accept) begin
            s1_v_reg   <= 1'b1;
            s1_id_reg  <= grant_id;
            s1_tag_reg <= sel_tag;
            s1_a_reg   <= sel_a;
            s1_b_reg   <= sel_b;
        end else if (s1_adv) begin
            s1_v_reg   <= 1'b0;
        end
    end

    // The multiplier only ever sees registered operands; zero when idle so
    // it does not toggle on stale data.
    assign mm_in1 = s1_v_reg ? s1_a_reg : '0;
    assign mm_in2 = s1_v_reg ? s1_b_reg : '0;

    // -------------------------------------------------------------------------
    // S2: result register. Captures the multiplier output when S1 advances;
    // otherwise clears once the response is taken. Contents are untouched
    // while a response waits on rsp_ready.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg    <= 1'b0;
            s2_id_reg   <= 1'b0;
            s2_tag_reg  <= '0;
            s2_data_reg <= '0;
        end else if (s1_adv) begin
            s2_v_reg    <= 1'b1;
            s2_id_reg   <= s1_id_reg;
            s2_tag_reg  <= s1_tag_reg;
            s2_data_reg <= mm_out;
        end else if (s2_v_reg && rsp_ready) begin
            s2_v_reg    <= 1'b0;
        end
    end

    assign rsp_valid = s2_v_reg;
    assign rsp_id    = s2_id_reg;
    assign rsp_tag   = s2_tag_reg;
    assign rsp_data  = s2_data_reg;

endmodule

// File: tb/tb_mm_arbiter.sv
module tb_mm_arbiter;

    localparam int DW   = 14;
    localparam int TW   = 4;
    localparam longint P    = 12289;
    localparam longint RINV = 9216;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready;
    logic [DW-1:0] req0_a, req0_b;
    logic [TW-1:0] req0_tag;
    logic          req1_valid, req1_ready;
    logic [DW-1:0] req1_a, req1_b;
    logic [TW-1:0] req1_tag;
    logic [DW-1:0] mm_in1, mm_in2, mm_out;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    mm_arbiter #(.DW(DW), .TW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .mm_in1     (mm_in1),
        .mm_in2     (mm_in2),
        .mm_out     (mm_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_data   (rsp_data)
    );

    // Golden Montgomery product a*b*R^-1 mod P, also standing in for normal_mm.
    function automatic logic [DW-1:0] golden(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint t;
        t = (longint'(a) * longint'(b)) % P;
        t = (t * RINV) % P;
        return DW'(t);
    endfunction

    assign mm_out = golden(mm_in1, mm_in2);

    // Reference model: an ordered list of in-flight operations with their age
    // in clock edges since accept. At most two may be held; the oldest is
    // presented once it has been held for two edges.
    typedef struct {
        bit id;
        int tag;
        int a;
        int b;
        int age;
    } op_t;

    op_t q[$];
    bit  last_m = 1'b1;
    bit  acc0, acc1;
    int  acc_log[$];
    int  checks = 0;
    int  errors = 0;
    int  last_rsp_data, last_rsp_id, last_rsp_tag;

    task automatic check(input string name, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven. Checks the
    // DUT against the model, then advances the model on the rising edge.
    task automatic cycle();
        int n, idx;
        bit vis, cons, cap, gv, g, er0, er1, has_s1;
        op_t e;
        #1;
        n    = q.size();
        vis  = (n > 0) && (q[0].age >= 2);
        cons = vis && rsp_ready;
        cap  = (n - int'(cons)) < 2;
        gv   = req0_valid || req1_valid;
        g    = (req0_valid && req1_valid) ? !last_m : (req1_valid && !req0_valid);
        er0  = cap && gv && !g;
        er1  = cap && gv && g;
        check("req0_ready", req0_ready, er0);
        check("req1_ready", req1_ready, er1);
        check("rsp_valid", rsp_valid, vis);
        has_s1 = (n == 2) || (n == 1 && q[0].age == 1);
        idx    = n - 1;
        check("mm_in1", mm_in1, has_s1 ? q[idx].a : 0);
        check("mm_in2", mm_in2, has_s1 ? q[idx].b : 0);
        if (vis) begin
            check("rsp_data", rsp_data, golden(DW'(q[0].a), DW'(q[0].b)));
            check("rsp_id", rsp_id, q[0].id);
            check("rsp_tag", rsp_tag, q[0].tag);
            if (cons) begin
                last_rsp_data = int'(rsp_data);
                last_rsp_id   = int'(rsp_id);
                last_rsp_tag  = int'(rsp_tag);
                $display("rsp id=%0d tag=%0d data=%0d", rsp_id, rsp_tag, rsp_data);
            end
        end
        @(posedge clk);
        acc0 = er0 && req0_valid;
        acc1 = er1 && req1_valid;
        if (cons) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc0 || acc1) begin
            e.id  = acc1;
            e.tag = acc1 ? int'(req1_tag) : int'(req0_tag);
            e.a   = acc1 ? int'(req1_a)   : int'(req0_a);
            e.b   = acc1 ? int'(req1_b)   : int'(req0_b);
            e.age = 1;
            q.push_back(e);
            last_m = acc1;
            acc_log.push_back(int'(acc1));
        end
    endtask

    // New operands only when the previous request was accepted or absent;
    // a pending request keeps valid, a, b and tag stable.
    task automatic stim(input bit want0, input bit want1, input bit rdy);
        if (!(req0_valid && !acc0)) begin
            req0_valid = want0;
            req0_a     = DW'($urandom_range(0, 12288));
            req0_b     = DW'($urandom_range(0, 12288));
            req0_tag   = TW'($urandom);
        end
        if (!(req1_valid && !acc1)) begin
            req1_valid = want1;
            req1_a     = DW'($urandom_range(0, 12288));
            req1_b     = DW'($urandom_range(0, 12288));
            req1_tag   = TW'($urandom);
        end
        rsp_ready = rdy;
    endtask

    task automatic single(input int a, input int b, input int tag);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = DW'(a); req0_b = DW'(b); req0_tag = TW'(tag);
        req1_valid = 1'b0; rsp_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            cycle();
        end
    endtask

    initial begin
        int cnt, accepted, cyc;
        req0_valid = 1'b1; req0_a = 14'd7; req0_b = 14'd9; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_a = 14'd3; req1_b = 14'd4; req1_tag = 4'd2;
        rsp_ready  = 1'b1;
        acc0 = 1'b0; acc1 = 1'b0;

        // Reset state, with both requesters asserting valid
        #12;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_mm_in1", mm_in1, 0);
        check("rst_mm_in2", mm_in2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // Single operations with known results
        single(12288, 12288, 3);
        check("single_data", last_rsp_data, 9216);
        check("single_id", last_rsp_id, 0);
        check("single_tag", last_rsp_tag, 3);
        single(0, 5, 4);
        check("zero_data", last_rsp_data, 0);
        single(1, 1, 5);
        check("one_data", last_rsp_data, 9216);

        // Idle: nothing in flight, multiplier inputs stay zero
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stim(0, 0, 1); cycle();
        end

        // Single requester streaming: accepted every cycle
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); stim(1, 0, 1); cycle();
            cnt += int'(acc0);
        end
        check("stream_accepts", cnt, 6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); stim(0, 0, 1); cycle();
        end

        // Backpressure: one result parked in S2, then a stalled stream on req1
        @(negedge clk); stim(0, 1, 1); cycle();
        @(negedge clk); stim(0, 0, 1); cycle();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); stim(0, 1, 0); cycle();
            cnt += int'(acc1);
        end
        check("bp_accepts", cnt, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); stim(0, 1, 1); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); stim(0, 0, 1); cycle();
        end
        check("bp_drained", q.size(), 0);

        // Reset with S1 and S2 both full
        @(negedge clk); stim(1, 0, 0); cycle();
        @(negedge clk); stim(1, 0, 0); cycle();
        check("mid_inflight", q.size(), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_req0_ready", req0_ready, 0);
        check("mid_mm_in1", mm_in1, 0);
        q.delete();
        last_m = 1'b1;
        acc0 = 1'b0; acc1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie from reset: strict alternation starting with requester 0
        acc_log.delete();
        stim(1, 1, 1); cycle();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); stim(1, 1, 1); cycle();
        end
        check("tie_count", acc_log.size(), 8);
        foreach (acc_log[i]) check("tie_order", acc_log[i], i % 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); stim(0, 0, 1); cycle();
        end

        // Random traffic
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            @(negedge clk);
            stim($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            cycle();
            accepted += int'(acc0) + int'(acc1);
            cyc++;
        end
        check("rand_accepts", accepted >= 1000, 1);
        acc0 = 1'b1; acc1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); stim(0, 0, 1); cycle();
        end
        check("rand_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
